uart_tx_cfg: RTL and testbench

Parametrised UART transmitter for the UART TX path. It serialises a DATA_WIDTH-bit word into an asynchronous frame: start bit, data bits LSB first, optional even/odd parity, then one or two stop bits.
- Bit period is set at run time by an internal baud divider.
- Frame options and data are captured at accept, so upstream may change them mid-frame.
- Sits between the system-side data producer (register file / async FIFO read side) and the TX pin.

---
 rtl/uart_tx_cfg.sv | 159 +++++++++++++++
 tb/tb_uart_tx_cfg.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: run-time configurable UART transmitter.
// A frame is a start bit, DATA_WIDTH data bits sent LSB first, an optional
// even/odd parity bit, and one or two stop bits. The data word, the framing
// options and the baud divider are all captured into shadow registers when a
// word is accepted. The producer may therefore change its inputs while a frame
// is still being sent.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  Baud_Div,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_bit;
  logic                  r_par_en;
  logic                  r_par;
  logic                  r_stop2;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  // A divider of 0 would never terminate a bit, so it is promoted to 1.
  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic                  w_bit_end;
  logic                  w_last_bit;

  assign w_div_eff  = (Baud_Div == '0) ? DIV_WIDTH'(1) : Baud_Div;
  assign w_bit_end  = (r_cnt == (r_div - DIV_WIDTH'(1)));
  assign w_last_bit = (r_bit == IDX_W'(DATA_WIDTH - 1));

  // Frame sequencer. The line, busy and tx_done are registered together with
  // the state, so each output already holds its value for the state entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= '0;
      r_shift  <= '0;
      r_bit    <= '0;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_stop2  <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The bit-period counter runs in every non-idle state.
      if (r_state != S_IDLE) begin
        r_cnt <= w_bit_end ? '0 : (r_cnt + DIV_WIDTH'(1));
      end
      case (r_state)
        S_IDLE: begin
          if (Data_Valid) begin
            r_shift  <= P_DATA;
            r_par_en <= PAR_EN;
            r_par    <= (^P_DATA) ^ PAR_TYP;
            r_stop2  <= STOP2;
            r_div    <= w_div_eff;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= S_STOP1;
                r_tx    <= 1'b1;
              end
            end else begin
              // The shift register keeps the next data bit at position 1.
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + IDX_W'(1);
              r_tx    <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP1;
            r_tx    <= 1'b1;
          end
        end
        S_STOP1: begin
          if (w_bit_end) begin
            if (r_stop2) begin
              r_state <= S_STOP2;
              r_tx    <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_STOP2: begin
          if (w_bit_end) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT  = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg. It uses an 8-bit instance for most
// frames and a 7-bit instance for the narrow-word case. Expected frames are
// written out by hand as {stop(s), parity, data, start}, sent from bit 0 upward.
module tb_uart_tx_cfg;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  pdata;
  logic        dv;
  logic        par_en;
  logic        par_typ;
  logic        stop2;
  logic [15:0] div;
  logic        sel;

  logic tx8, busy8, done8;
  logic tx7, busy7, done7;

  wire dv8    = dv & ~sel;
  wire dv7    = dv & sel;
  wire s_tx   = sel ? tx7   : tx8;
  wire s_busy = sel ? busy7 : busy8;
  wire s_done = sel ? done7 : done8;

  always #5 CLK = ~CLK;

  uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut8 (
    .CLK(CLK), .RST(RST), .P_DATA(pdata), .Data_Valid(dv8),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .Baud_Div(div),
    .TX_OUT(tx8), .busy(busy8), .tx_done(done8)
  );

  uart_tx_cfg #(.DATA_WIDTH(7), .DIV_WIDTH(16)) dut7 (
    .CLK(CLK), .RST(RST), .P_DATA(pdata[6:0]), .Data_Valid(dv7),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .Baud_Div(div),
    .TX_OUT(tx7), .busy(busy7), .tx_done(done7)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with Data_Valid already raised. Checks every cycle of
  // the frame, then the tx_done cycle. keep_dv leaves Data_Valid high and loads
  // next_data for a back-to-back frame. pert_at >= 0 disturbs the inputs at
  // that cycle of the frame.
  task automatic run_frame(input string tag, input logic [15:0] bits, input int nbits,
                           input int d, input bit keep_dv, input logic [7:0] next_data,
                           input int pert_at);
    @(negedge CLK);
    if (!keep_dv) dv = 1'b0;
    for (int c = 0; c < nbits * d; c++) begin
      check({tag, "_tx"}, 32'(s_tx), 32'(bits[c / d]));
      check({tag, "_busy"}, 32'(s_busy), 32'd1);
      check({tag, "_done_lo"}, 32'(s_done), 32'd0);
      if (pert_at >= 0 && c == pert_at) begin
        pdata  = 8'hFF;
        par_en = ~par_en;
        dv     = 1'b1;
      end
      if (pert_at >= 0 && c == pert_at + 2) dv = 1'b0;
      @(negedge CLK);
    end
    check({tag, "_done"}, 32'(s_done), 32'd1);
    check({tag, "_end_busy"}, 32'(s_busy), 32'd0);
    check({tag, "_end_tx"}, 32'(s_tx), 32'd1);
    if (keep_dv) pdata = next_data;
  endtask

  initial begin
    RST = 1'b1; dv = 1'b0; sel = 1'b0; pdata = 8'h00;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; div = 16'd1;
    #1 RST = 1'b0;
    #3;
    check("rst_tx8", 32'(tx8), 32'd1);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_tx7", 32'(tx7), 32'd1);
    check("rst_busy7", 32'(busy7), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_busy", 32'(busy8), 32'd0);
    check("idle_tx", 32'(tx8), 32'd1);

    // 0xA5 has four ones, so the even parity bit is 0.
    pdata = 8'hA5; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; div = 16'd1; dv = 1'b1;
    run_frame("a5", {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1, 1'b0, 8'h00, -1);
    @(negedge CLK);
    check("a5_done_one", 32'(done8), 32'd0);

    // 0x01 has one one, so the odd parity bit is 0; two stop bits, 4 clocks each.
    pdata = 8'h01; par_en = 1'b1; par_typ = 1'b1; stop2 = 1'b1; div = 16'd4; dv = 1'b1;
    run_frame("x01", {4'b0, 2'b11, 1'b0, 8'h01, 1'b0}, 12, 4, 1'b0, 8'h00, -1);
    @(negedge CLK);

    // Divider 0 acts as 1; Data_Valid stays high for two back-to-back frames.
    pdata = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; div = 16'd0; dv = 1'b1;
    run_frame("b2b_3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1, 1'b1, 8'hC3, -1);
    run_frame("b2b_c3", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 1, 1'b0, 8'h00, -1);
    @(negedge CLK);
    check("b2b_after_busy", 32'(busy8), 32'd0);
    check("b2b_after_done", 32'(done8), 32'd0);

    // 0x55 with even parity (bit 0). Inputs are disturbed during the data bits.
    pdata = 8'h55; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; div = 16'd2; dv = 1'b1;
    run_frame("mid", {5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, 2, 1'b0, 8'h00, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("mid_no_restart_busy", 32'(busy8), 32'd0);
      check("mid_no_restart_tx", 32'(tx8), 32'd1);
    end

    // Reset during data bit 3 of 0xF0, where the line is low.
    pdata = 8'hF0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; div = 16'd1; dv = 1'b1;
    @(negedge CLK);
    dv = 1'b0;
    check("abort_start", 32'(tx8), 32'd0);
    for (int c = 1; c < 4; c++) begin
      @(negedge CLK);
      check("abort_low_bits", 32'(tx8), 32'd0);
    end
    @(negedge CLK);
    check("abort_bit3", 32'(tx8), 32'd0);
    #2 RST = 1'b0;
    #1;
    check("abort_tx", 32'(tx8), 32'd1);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_no_done", 32'(done8), 32'd0);
      check("abort_idle_busy", 32'(busy8), 32'd0);
    end
    pdata = 8'h0F; div = 16'd3; dv = 1'b1;
    run_frame("post_rst", {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 3, 1'b0, 8'h00, -1);
    @(negedge CLK);

    // 7-bit instance: seven ones give an even parity bit of 1, 10 bits in all.
    sel = 1'b1;
    pdata = 8'h7F; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; div = 16'd1; dv = 1'b1;
    run_frame("w7", {6'b0, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, 1, 1'b0, 8'h00, -1);
    check("w7_dut8_idle", 32'(busy8), 32'd0);
    @(negedge CLK);
    check("w7_done_one", 32'(done7), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
